// File: rtl/fetcher.sv
// fetcher: RV32I instruction fetch stage. Requests one word at a time from the icache,
// predicts the next PC and pushes the word, its PC and the prediction into the instruction queue.
module fetcher (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        out_icache_valid,
    output logic [31:0] out_icache_addr,
    input  logic        in_icache_ready,
    input  logic [31:0] in_icache_inst,
    output logic [7:0]  out_bp_tag,
    input  logic        in_bp_jump_res,
    input  logic        in_iq_full,
    output logic        out_iq_valid,
    output logic [31:0] out_iq_inst,
    output logic [31:0] out_iq_pc,
    output logic        out_iq_pred_jump,
    input  logic        in_rob_flush,
    input  logic [31:0] in_rob_target_pc
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] held_inst;
    logic [31:0] held_next_pc;
    logic        held_pred;

    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic [31:0] pred_next_pc;
    logic        pred_taken;

    assign out_bp_tag = pc[9:2];

    assign imm_j = {{11{in_icache_inst[31]}}, in_icache_inst[31], in_icache_inst[19:12],
                    in_icache_inst[20], in_icache_inst[30:21], 1'b0};
    assign imm_b = {{19{in_icache_inst[31]}}, in_icache_inst[31], in_icache_inst[7],
                    in_icache_inst[30:25], in_icache_inst[11:8], 1'b0};

    // JAL always redirects; conditional branches follow the predictor; everything else falls through.
    always_comb begin
        pred_taken   = 1'b0;
        pred_next_pc = pc + 32'd4;
        if (in_icache_inst[6:0] == OP_JAL) begin
            pred_taken   = 1'b1;
            pred_next_pc = pc + imm_j;
        end else if (in_icache_inst[6:0] == OP_BRANCH && in_bp_jump_res) begin
            pred_taken   = 1'b1;
            pred_next_pc = pc + imm_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            pc               <= 32'd0;
            held_inst        <= 32'd0;
            held_next_pc     <= 32'd0;
            held_pred        <= 1'b0;
            out_icache_valid <= 1'b0;
            out_icache_addr  <= 32'd0;
            out_iq_valid     <= 1'b0;
            out_iq_inst      <= 32'd0;
            out_iq_pc        <= 32'd0;
            out_iq_pred_jump <= 1'b0;
        end else if (rdy) begin
            out_iq_valid <= 1'b0;
            if (in_rob_flush) begin
                pc               <= in_rob_target_pc;
                out_icache_valid <= 1'b0;
                // An icache response still in flight must be swallowed before refetching.
                if ((state == WAIT || state == DROP) && !in_icache_ready)
                    state <= DROP;
                else
                    state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        out_icache_valid <= 1'b1;
                        out_icache_addr  <= pc;
                        state            <= WAIT;
                    end
                    WAIT: begin
                        if (in_icache_ready) begin
                            out_icache_valid <= 1'b0;
                            if (!in_iq_full) begin
                                out_iq_valid     <= 1'b1;
                                out_iq_inst      <= in_icache_inst;
                                out_iq_pc        <= pc;
                                out_iq_pred_jump <= pred_taken;
                                pc               <= pred_next_pc;
                                state            <= IDLE;
                            end else begin
                                held_inst    <= in_icache_inst;
                                held_next_pc <= pred_next_pc;
                                held_pred    <= pred_taken;
                                state        <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (!in_iq_full) begin
                            out_iq_valid     <= 1'b1;
                            out_iq_inst      <= held_inst;
                            out_iq_pc        <= pc;
                            out_iq_pred_jump <= held_pred;
                            pc               <= held_next_pc;
                            state            <= IDLE;
                        end
                    end
                    DROP: begin
                        if (in_icache_ready)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetcher.sv
// tb_fetcher: directed scenarios plus a randomized run against an instruction-stream
// reference model for the fetcher.
module tb_fetcher;
    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] BEQ  = 32'h00000863;
    localparam logic [31:0] JALB = 32'hff9ff06f;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        out_icache_valid;
    logic [31:0] out_icache_addr;
    logic        in_icache_ready = 1'b0;
    logic [31:0] in_icache_inst = 32'd0;
    logic [7:0]  out_bp_tag;
    logic        in_bp_jump_res;
    logic        in_iq_full = 1'b0;
    logic        out_iq_valid;
    logic [31:0] out_iq_inst;
    logic [31:0] out_iq_pc;
    logic        out_iq_pred_jump;
    logic        in_rob_flush = 1'b0;
    logic [31:0] in_rob_target_pc = 32'd0;

    logic        use_table = 1'b0;
    logic        bp_val = 1'b0;
    logic        bp_table [256];
    int          checks = 0;
    int          passed = 0;
    int          cycle = 0;

    logic [31:0] inst_mem [64];
    logic [31:0] off_mem [64];
    int          kind_mem [64];

    assign in_bp_jump_res = use_table ? bp_table[out_bp_tag] : bp_val;

    fetcher dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .out_icache_valid(out_icache_valid), .out_icache_addr(out_icache_addr),
        .in_icache_ready(in_icache_ready), .in_icache_inst(in_icache_inst),
        .out_bp_tag(out_bp_tag), .in_bp_jump_res(in_bp_jump_res),
        .in_iq_full(in_iq_full), .out_iq_valid(out_iq_valid),
        .out_iq_inst(out_iq_inst), .out_iq_pc(out_iq_pc),
        .out_iq_pred_jump(out_iq_pred_jump),
        .in_rob_flush(in_rob_flush), .in_rob_target_pc(in_rob_target_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reset, then redirect the idle fetcher to a chosen start PC.
    task automatic restart(input logic [31:0] target);
        rst = 1'b0; rdy = 1'b1; in_icache_ready = 1'b0; in_iq_full = 1'b0; in_rob_flush = 1'b0;
        step;
        rst = 1'b1; in_rob_flush = 1'b1; in_rob_target_pc = target;
        step;
        in_rob_flush = 1'b0;
    endtask

    task automatic serve(input logic [31:0] inst, input int lat);
        repeat (lat) step;
        in_icache_ready = 1'b1; in_icache_inst = inst;
        step;
        in_icache_ready = 1'b0;
    endtask

    task automatic test_reset;
        rdy = 1'b1;
        repeat (3) step;
        checks++;
        if ({out_icache_valid, out_icache_addr, out_iq_valid, out_iq_inst, out_iq_pc, out_iq_pred_jump} !== 98'd0)
            $display("[TB] FAIL reset_outputs: got v=%0b a=%h iqv=%0b i=%h p=%h j=%0b want all 0",
                     out_icache_valid, out_icache_addr, out_iq_valid, out_iq_inst, out_iq_pc, out_iq_pred_jump);
        else passed++;
        checks++;
        if (out_bp_tag !== 8'h00) $display("[TB] FAIL reset_tag: got %h want 00", out_bp_tag);
        else passed++;
        rst = 1'b1;
        step;
        checks++;
        if (out_icache_valid !== 1'b1 || out_icache_addr !== 32'h0)
            $display("[TB] FAIL reset_first_req: got v=%0b a=%h want v=1 a=0", out_icache_valid, out_icache_addr);
        else passed++;
    endtask

    task automatic test_sequential;
        int last_push;
        logic [31:0] e;
        last_push = 0;
        restart(32'h0);
        step;
        for (int k = 0; k < 3; k++) begin
            e = 32'(4 * k);
            checks++;
            if (out_icache_valid !== 1'b1 || out_icache_addr !== e)
                $display("[TB] FAIL seq_req: got v=%0b a=%h want v=1 a=%h", out_icache_valid, out_icache_addr, e);
            else passed++;
            serve(ADDI, 1);
            checks++;
            if ({out_iq_valid, out_iq_pc, out_iq_inst, out_iq_pred_jump, out_icache_valid} !== {1'b1, e, ADDI, 1'b0, 1'b0})
                $display("[TB] FAIL seq_push: got iqv=%0b pc=%h i=%h j=%0b v=%0b want iqv=1 pc=%h i=%h j=0 v=0",
                         out_iq_valid, out_iq_pc, out_iq_inst, out_iq_pred_jump, out_icache_valid, e, ADDI);
            else passed++;
            if (k > 0) begin
                checks++;
                if (cycle - last_push !== 3)
                    $display("[TB] FAIL seq_spacing: got %0d cycles want 3", cycle - last_push);
                else passed++;
            end
            last_push = cycle;
            step;
            checks++;
            if (out_iq_valid !== 1'b0) $display("[TB] FAIL seq_strobe_width: got %0b want 0", out_iq_valid);
            else passed++;
        end
    endtask

    task automatic test_branch;
        for (int t = 1; t >= 0; t--) begin
            restart(32'h100);
            checks++;
            if (out_bp_tag !== 8'h40) $display("[TB] FAIL br_tag: got %h want 40", out_bp_tag);
            else passed++;
            step;
            bp_val = 1'(t);
            serve(BEQ, 1);
            checks++;
            if ({out_iq_valid, out_iq_pc, out_iq_inst, out_iq_pred_jump} !== {1'b1, 32'h100, BEQ, 1'(t)})
                $display("[TB] FAIL br_push: got iqv=%0b pc=%h i=%h j=%0b want iqv=1 pc=100 j=%0d",
                         out_iq_valid, out_iq_pc, out_iq_inst, out_iq_pred_jump, t);
            else passed++;
            step;
            checks++;
            if (out_icache_addr !== (t == 1 ? 32'h110 : 32'h104))
                $display("[TB] FAIL br_next_addr: got %h want %h", out_icache_addr, (t == 1 ? 32'h110 : 32'h104));
            else passed++;
        end
        bp_val = 1'b0;
    endtask

    task automatic test_jal;
        restart(32'h200);
        step;
        bp_val = 1'b0;
        serve(JALB, 1);
        checks++;
        if ({out_iq_valid, out_iq_pc, out_iq_pred_jump} !== {1'b1, 32'h200, 1'b1})
            $display("[TB] FAIL jal_push: got iqv=%0b pc=%h j=%0b want iqv=1 pc=200 j=1",
                     out_iq_valid, out_iq_pc, out_iq_pred_jump);
        else passed++;
        step;
        checks++;
        if (out_icache_valid !== 1'b1 || out_icache_addr !== 32'h1F8)
            $display("[TB] FAIL jal_next_addr: got v=%0b a=%h want v=1 a=1f8", out_icache_valid, out_icache_addr);
        else passed++;
    endtask

    task automatic test_backpressure;
        restart(32'h300);
        step;
        bp_val = 1'b1;
        in_iq_full = 1'b1;
        serve(BEQ, 1);
        bp_val = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_iq_valid !== 1'b0 || out_icache_valid !== 1'b0)
                $display("[TB] FAIL bp_hold: cycle %0d got iqv=%0b v=%0b want 0 0", i, out_iq_valid, out_icache_valid);
            else passed++;
            if (i < 3) step;
        end
        in_iq_full = 1'b0;
        step;
        checks++;
        if ({out_iq_valid, out_iq_pc, out_iq_inst, out_iq_pred_jump} !== {1'b1, 32'h300, BEQ, 1'b1})
            $display("[TB] FAIL bp_push: got iqv=%0b pc=%h i=%h j=%0b want iqv=1 pc=300 j=1",
                     out_iq_valid, out_iq_pc, out_iq_inst, out_iq_pred_jump);
        else passed++;
        step;
        checks++;
        if (out_icache_valid !== 1'b1 || out_icache_addr !== 32'h310)
            $display("[TB] FAIL bp_next_addr: got v=%0b a=%h want v=1 a=310", out_icache_valid, out_icache_addr);
        else passed++;
    endtask

    task automatic test_flush_wait;
        restart(32'h380);
        step;
        in_rob_flush = 1'b1; in_rob_target_pc = 32'h400;
        step;
        in_rob_flush = 1'b0;
        checks++;
        if (out_icache_valid !== 1'b0 || out_iq_valid !== 1'b0)
            $display("[TB] FAIL flush_drop_enter: got v=%0b iqv=%0b want 0 0", out_icache_valid, out_iq_valid);
        else passed++;
        step;
        in_icache_ready = 1'b1; in_icache_inst = ADDI;
        step;
        in_icache_ready = 1'b0;
        checks++;
        if (out_icache_valid !== 1'b0 || out_iq_valid !== 1'b0)
            $display("[TB] FAIL flush_drop_discard: got v=%0b iqv=%0b want 0 0", out_icache_valid, out_iq_valid);
        else passed++;
        step;
        checks++;
        if (out_icache_valid !== 1'b1 || out_icache_addr !== 32'h400)
            $display("[TB] FAIL flush_drop_refetch: got v=%0b a=%h want v=1 a=400", out_icache_valid, out_icache_addr);
        else passed++;
        serve(ADDI, 1);
        checks++;
        if (out_iq_valid !== 1'b1 || out_iq_pc !== 32'h400)
            $display("[TB] FAIL flush_resume_push: got iqv=%0b pc=%h want 1 400", out_iq_valid, out_iq_pc);
        else passed++;
        step;
        in_icache_ready = 1'b1; in_icache_inst = ADDI;
        in_rob_flush = 1'b1; in_rob_target_pc = 32'h500;
        step;
        in_icache_ready = 1'b0; in_rob_flush = 1'b0;
        checks++;
        if (out_iq_valid !== 1'b0 || out_icache_valid !== 1'b0)
            $display("[TB] FAIL flush_coincident: got iqv=%0b v=%0b want 0 0", out_iq_valid, out_icache_valid);
        else passed++;
        step;
        checks++;
        if (out_icache_valid !== 1'b1 || out_icache_addr !== 32'h500)
            $display("[TB] FAIL flush_coincident_req: got v=%0b a=%h want v=1 a=500", out_icache_valid, out_icache_addr);
        else passed++;
    endtask

    task automatic test_async_reset_rdy;
        restart(32'h600);
        step;
        in_iq_full = 1'b1;
        serve(ADDI, 1);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_icache_valid, out_icache_addr, out_iq_valid, out_iq_inst, out_iq_pc, out_iq_pred_jump, out_bp_tag} !== 106'd0)
            $display("[TB] FAIL async_reset: got v=%0b a=%h iqv=%0b pc=%h tag=%h want all 0",
                     out_icache_valid, out_icache_addr, out_iq_valid, out_iq_pc, out_bp_tag);
        else passed++;
        in_iq_full = 1'b0;
        step;
        rst = 1'b1;
        step;
        checks++;
        if (out_icache_valid !== 1'b1 || out_icache_addr !== 32'h0 || out_iq_valid !== 1'b0)
            $display("[TB] FAIL async_reset_restart: got v=%0b a=%h iqv=%0b want 1 0 0",
                     out_icache_valid, out_icache_addr, out_iq_valid);
        else passed++;
        rdy = 1'b0;
        in_icache_ready = 1'b1; in_icache_inst = ADDI;
        for (int i = 0; i < 4; i++) begin
            step;
            checks++;
            if (out_icache_valid !== 1'b1 || out_icache_addr !== 32'h0 || out_iq_valid !== 1'b0)
                $display("[TB] FAIL rdy_freeze: cycle %0d got v=%0b a=%h iqv=%0b want 1 0 0",
                         i, out_icache_valid, out_icache_addr, out_iq_valid);
            else passed++;
        end
        rdy = 1'b1;
        step;
        in_icache_ready = 1'b0;
        checks++;
        if (out_iq_valid !== 1'b1 || out_iq_pc !== 32'h0 || out_iq_inst !== ADDI)
            $display("[TB] FAIL rdy_resume_push: got iqv=%0b pc=%h i=%h want 1 0 %h", out_iq_valid, out_iq_pc, out_iq_inst, ADDI);
        else passed++;
        step;
        checks++;
        if (out_icache_valid !== 1'b1 || out_icache_addr !== 32'h4)
            $display("[TB] FAIL rdy_resume_req: got v=%0b a=%h want 1 4", out_icache_valid, out_icache_addr);
        else passed++;
    endtask

    // Random program, predictor, icache latency, backpressure, stalls and flushes. The model
    // is just the expected instruction stream: each push must be the next word on the predicted path.
    task automatic test_random;
        logic [31:0] exp_pc, req_addr, off, snap_addr, snap_pc, snap_inst;
        logic [20:0] j;
        logic [12:0] b;
        logic        snap_valid, snap_iqv, snap_pred, taken;
        logic        prev_rdy, prev_full, prev_flush, prev_iqv, prev_valid, pending;
        int          cnt, pushes, idx, r;
        for (int i = 0; i < 256; i++) bp_table[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 64; i++) begin
            r = int'($urandom_range(0, 9));
            off = ($urandom_range(0, 511) - 256) * 4;
            j = off[20:0];
            b = off[12:0];
            off_mem[i] = off;
            if (r >= 7) begin
                kind_mem[i] = 1;
                inst_mem[i] = {j[20], j[10:1], j[11], j[19:12], 5'd1, 7'b1101111};
            end else if (r >= 4) begin
                kind_mem[i] = 2;
                inst_mem[i] = {b[12], b[10:5], 5'd2, 5'd1, 3'b000, b[4:1], b[11], 7'b1100011};
            end else begin
                kind_mem[i] = 0;
                inst_mem[i] = {$urandom_range(0, 4095), 5'd1, 3'b000, 5'd1, (r == 0 ? 7'b1100111 : 7'b0010011)};
            end
        end
        use_table = 1'b1;
        exp_pc = $urandom & 32'hFFFF_FFFC;
        restart(exp_pc);
        prev_rdy = 1'b1; prev_full = 1'b0; prev_flush = 1'b1; prev_iqv = 1'b0; prev_valid = 1'b0;
        pending = 1'b0; pushes = 0; cnt = 0; req_addr = 32'd0;
        snap_valid = 1'b0; snap_addr = 32'd0; snap_iqv = 1'b0; snap_pc = 32'd0; snap_inst = 32'd0; snap_pred = 1'b0;
        for (int it = 0; it < 4000; it++) begin
            if (!prev_rdy) begin
                checks++;
                if ({out_icache_valid, out_icache_addr, out_iq_valid, out_iq_pc, out_iq_inst, out_iq_pred_jump} !==
                    {snap_valid, snap_addr, snap_iqv, snap_pc, snap_inst, snap_pred})
                    $display("[TB] FAIL rnd_freeze: it %0d got v=%0b a=%h iqv=%0b want v=%0b a=%h iqv=%0b",
                             it, out_icache_valid, out_icache_addr, out_iq_valid, snap_valid, snap_addr, snap_iqv);
                else passed++;
            end else if (out_iq_valid) begin
                checks++;
                if (prev_flush || prev_full || prev_iqv)
                    $display("[TB] FAIL rnd_push_allowed: it %0d got push want none (flush=%0b full=%0b prev_push=%0b)",
                             it, prev_flush, prev_full, prev_iqv);
                else passed++;
                idx = int'(exp_pc[7:2]);
                taken = (kind_mem[idx] == 1) || (kind_mem[idx] == 2 && bp_table[exp_pc[9:2]]);
                checks++;
                if ({out_iq_pc, out_iq_inst, out_iq_pred_jump} !== {exp_pc, inst_mem[idx], taken})
                    $display("[TB] FAIL rnd_push_data: it %0d got pc=%h i=%h j=%0b want pc=%h i=%h j=%0b",
                             it, out_iq_pc, out_iq_inst, out_iq_pred_jump, exp_pc, inst_mem[idx], taken);
                else passed++;
                exp_pc = taken ? exp_pc + off_mem[idx] : exp_pc + 32'd4;
                pushes++;
            end
            if (in_icache_ready && prev_rdy) in_icache_ready = 1'b0;
            if (out_icache_valid && !prev_valid) begin
                checks++;
                if (out_icache_addr !== exp_pc)
                    $display("[TB] FAIL rnd_req_addr: it %0d got %h want %h", it, out_icache_addr, exp_pc);
                else passed++;
                pending = 1'b1;
                req_addr = out_icache_addr;
                cnt = int'($urandom_range(0, 3));
            end
            if (pending && !in_icache_ready) begin
                if (cnt == 0) begin
                    in_icache_ready = 1'b1;
                    in_icache_inst = inst_mem[req_addr[7:2]];
                    pending = 1'b0;
                end else cnt--;
            end
            rdy = ($urandom_range(0, 7) != 0);
            in_iq_full = ($urandom_range(0, 3) == 0);
            in_rob_flush = rdy && ($urandom_range(0, 29) == 0);
            if (in_rob_flush) begin
                in_rob_target_pc = $urandom & 32'hFFFF_FFFC;
                exp_pc = in_rob_target_pc;
            end
            snap_valid = out_icache_valid; snap_addr = out_icache_addr; snap_iqv = out_iq_valid;
            snap_pc = out_iq_pc; snap_inst = out_iq_inst; snap_pred = out_iq_pred_jump;
            prev_rdy = rdy; prev_full = in_iq_full; prev_flush = in_rob_flush;
            prev_iqv = out_iq_valid; prev_valid = out_icache_valid;
            step;
        end
        in_rob_flush = 1'b0; in_icache_ready = 1'b0; rdy = 1'b1; use_table = 1'b0;
        checks++;
        if (pushes < 100) $display("[TB] FAIL rnd_progress: got %0d pushes want at least 100", pushes);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_branch;
        test_jal;
        test_backpressure;
        test_flush_wait;
        test_async_reset_rdy;
        test_random;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fetcher.md
# fetcher

Instruction fetch stage of the out-of-order RV32I core. It holds the architectural fetch PC and requests one instruction word at a time from the instruction cache. It queries the branch predictor with the PC-derived tag, computes the predicted next PC, and pushes the instruction with its PC and prediction into the instruction queue. A ROB flush redirects it to the resolved target.

## Interface
Parameters:
- none; widths are fixed for RV32: PC/instruction 32 bits, predictor tag 8 bits.

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; when low all state and registered outputs hold
- out_icache_valid  out  1  fetch request pending
- out_icache_addr  out  32  fetch address, stable while request pending
- in_icache_ready  in  1  one-cycle pulse: in_icache_inst is valid for the pending request
- in_icache_inst  in  32  returned instruction word
- out_bp_tag  out  8  combinational, = pc[9:2]
- in_bp_jump_res  in  1  predictor answer for out_bp_tag, same cycle, 1 = taken
- in_iq_full  in  1  instruction queue cannot accept a push next cycle
- out_iq_valid  out  1  one-cycle push strobe
- out_iq_inst  out  32  pushed instruction
- out_iq_pc  out  32  PC of pushed instruction
- out_iq_pred_jump  out  1  1 = fetcher redirected to the taken target
- in_rob_flush  in  1  misprediction/redirect from ROB commit
- in_rob_target_pc  in  32  new fetch PC on flush

## Operation
- State: pc[31:0], held instruction/next-PC registers, FSM state in {IDLE, WAIT, HOLD, DROP}.
- Reset (rst=0, any time, asynchronous):
  - pc=0, state=IDLE.
  - All outputs except out_bp_tag are 0.
  - Any pending or held work is lost.
- IDLE: registers out_icache_valid=1, out_icache_addr=pc; goes to WAIT.
- WAIT: out_icache_valid stays 1. On the cycle in_icache_ready=1, capture in_icache_inst and compute next_pc from the captured word:
  - opcode 1101111 (JAL): pc + sign-extended J-immediate; pred_jump=1.
  - opcode 1100011 (branch): if in_bp_jump_res=1, pc + sign-extended B-immediate, pred_jump=1; else pc+4, pred_jump=0.
  - all other opcodes, including JALR: pc+4, pred_jump=0.
  - Adds are modulo 2^32; wrap-around is not an error.
- Push rule, evaluated in the ready cycle:
  - If in_iq_full=0: next edge sets out_iq_valid=1 with inst/pc/pred, pc<=next_pc, out_icache_valid<=0, state<=IDLE.
  - If in_iq_full=1: out_icache_valid<=0, result held, state<=HOLD.
- HOLD: each cycle, if in_iq_full=0, push the held result (out_iq_valid=1 next edge), pc<=next_pc, state<=IDLE.
- DROP: waits for the in_icache_ready of an abandoned request, discards that word, then goes to IDLE. out_icache_valid=0 in DROP.
- Flush (in_rob_flush=1) has priority over everything except reset:
  - pc<=in_rob_target_pc; out_iq_valid<=0; any held instruction is discarded.
  - From WAIT with in_icache_ready=0: state<=DROP. From WAIT with in_icache_ready=1 in the same cycle: the word is dropped, state<=IDLE.
  - From IDLE or HOLD: state<=IDLE. From DROP with in_icache_ready=0: stays in DROP. From DROP with in_icache_ready=1: state<=IDLE.
  - After a flush no instruction from the old path is ever pushed.
- rdy=0 freezes FSM, pc and registered outputs. in_icache_ready is not sampled while rdy=0; the icache holds its pulse until rdy returns.

## Timing
- Request: out_icache_valid rises one cycle after entering IDLE and falls on the edge after in_icache_ready.
- Predictor lookup is same-cycle combinational; out_bp_tag tracks pc with zero latency.
- Minimum fetch-to-push: the push strobe appears on the edge after the ready cycle. Peak throughput is one instruction per 3 cycles (IDLE, WAIT, ready) with a 1-cycle icache.
- out_iq_valid is never high two consecutive cycles, and never high in the cycle after a flush.
- The first request after a flush is issued no earlier than 1 cycle after the flush cycle (IDLE path), or after the dropped response (DROP path).

## Test plan
- Reset then sequential fetch: release rst, icache returns addi (0x00100093) at 0x0, 0x4 and 0x8 -> pushes with out_iq_pc 0x0, 0x4, 0x8, pred_jump=0, one push per 3 cycles.
- Predicted-taken branch: pc=0x100, inst beq x0,x0,16 (0x00000863), out_bp_tag=0x40, in_bp_jump_res=1 -> push pred_jump=1, next request addr 0x110. Repeat with jump_res=0 -> next addr 0x104.
- JAL backward: pc=0x200, inst 0xff9ff06f (jal x0,-8) -> pred_jump=1, next addr 0x1F8, predictor answer ignored.
- Queue backpressure: hold in_iq_full=1 for 5 cycles across the ready cycle -> no push, no new request; push occurs on the edge after full drops, with the correct pc.
- Flush during WAIT: flush to 0x400 while waiting, icache responds 2 cycles later -> that word is not pushed, next request addr 0x400. Same test with flush coincident with ready -> direct to IDLE, no push.
- Async reset and rdy: assert rst mid-HOLD -> outputs 0 immediately without a clock edge. Drop rdy for 4 cycles mid-WAIT -> no state change, fetch resumes correctly.
